// File: rtl/persiana_actuador_if.sv
// Motor command / limit sensor bundle between the blind controller and the plant.
// master = controller side, slave = motor and limit-switch side.
interface persiana_actuador_if;
  logic       subir;
  logic       bajar;
  logic       Ssup;
  logic       Smed;
  logic       Sinf;
  logic [7:0] posicion;
  logic       moviendo;
  logic       falla;

  modport master (
    output subir,
    output bajar,
    input  Ssup,
    input  Smed,
    input  Sinf,
    input  posicion,
    input  moviendo,
    input  falla
  );

  modport slave (
    input  subir,
    input  bajar,
    output Ssup,
    output Smed,
    output Sinf,
    output posicion,
    output moviendo,
    output falla
  );
endinterface

// File: rtl/persiana_actuador.sv
// Behavioral blind motor with limit switches: one position step per PRESC
// cycles of held command, sticky fault when both commands are asserted.
module persiana_actuador #(
  parameter int TRAVEL   = 200,
  parameter int PRESC    = 4,
  parameter int MED_POS  = 100,
  parameter int INIT_POS = 0
) (
  input  logic                Reloj,
  input  logic                reset,
  persiana_actuador_if.slave  io
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [7:0]    TOP  = 8'(TRAVEL);
  localparam logic [7:0]    MED  = 8'(MED_POS);
  localparam logic [7:0]    INI  = 8'(INIT_POS);
  localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

  typedef enum logic [1:0] {
    PARADO,
    SUBIENDO,
    BAJANDO,
    FALLA
  } state_t;

  state_t        state_q;
  logic [7:0]    pos_q;
  logic [CW-1:0] cnt_q;
  logic          mov_q;
  logic          fal_q;

  logic up, dn, both;

  assign both = io.subir & io.bajar;
  assign up   = io.subir & ~io.bajar;
  assign dn   = io.bajar & ~io.subir;

  always_ff @(posedge Reloj or negedge reset) begin
    if (!reset) begin
      state_q <= PARADO;
      pos_q   <= INI;
      cnt_q   <= '0;
      mov_q   <= 1'b0;
      fal_q   <= 1'b0;
    end else begin
      unique case (state_q)
        PARADO: begin
          cnt_q <= '0;
          if (both) begin
            state_q <= FALLA;
            fal_q   <= 1'b1;
          end else if (up && pos_q < TOP) begin
            state_q <= SUBIENDO;
            mov_q   <= 1'b1;
          end else if (dn && pos_q != 8'd0) begin
            state_q <= BAJANDO;
            mov_q   <= 1'b1;
          end
        end

        SUBIENDO: begin
          if (both) begin
            state_q <= FALLA;
            mov_q   <= 1'b0;
            fal_q   <= 1'b1;
          end else if (!io.subir) begin
            // Dropping or reversing the command always passes through PARADO.
            state_q <= PARADO;
            mov_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (pos_q < TOP) begin
              pos_q <= pos_q + 8'd1;
            end
            if (pos_q + 8'd1 >= TOP) begin
              state_q <= PARADO;
              mov_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        BAJANDO: begin
          if (both) begin
            state_q <= FALLA;
            mov_q   <= 1'b0;
            fal_q   <= 1'b1;
          end else if (!io.bajar) begin
            state_q <= PARADO;
            mov_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (pos_q != 8'd0) begin
              pos_q <= pos_q - 8'd1;
            end
            if (pos_q <= 8'd1) begin
              state_q <= PARADO;
              mov_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        FALLA: begin
          state_q <= FALLA;
          mov_q   <= 1'b0;
          fal_q   <= 1'b1;
        end
      endcase
    end
  end

  assign io.posicion = pos_q;
  assign io.moviendo = mov_q;
  assign io.falla    = fal_q;
  assign io.Ssup     = (pos_q == TOP);
  assign io.Smed     = (pos_q == MED);
  assign io.Sinf     = (pos_q == 8'd0);

endmodule

// File: tb/tb_persiana_actuador.sv
// Closed-loop bench for the blind plant: TRAVEL=8, PRESC=4, MED_POS=4.
// Expected outputs are queued per edge and popped when the edge is sampled.
module tb_persiana_actuador;

  localparam int TRAV = 8;
  localparam int PR   = 4;
  localparam int MEDP = 4;

  logic Reloj;
  logic reset;
  int   checks;
  int   failures;

  logic [12:0] sb[$];

  persiana_actuador_if bus ();

  persiana_actuador #(
    .TRAVEL  (TRAV),
    .PRESC   (PR),
    .MED_POS (MEDP),
    .INIT_POS(0)
  ) dut (
    .Reloj(Reloj),
    .reset(reset),
    .io   (bus)
  );

  initial Reloj = 1'b0;
  always #5 Reloj = ~Reloj;

  // {posicion, moviendo, falla, Ssup, Smed, Sinf}
  function automatic logic [12:0] mk(input int p, input bit m, input bit f);
    logic [7:0] pp;
    pp = 8'(p);
    return {pp, m, f, (p == TRAV), (p == MEDP), (p == 0)};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.posicion, bus.moviendo, bus.falla,
            bus.Ssup, bus.Smed, bus.Sinf};
  endfunction

  task automatic tick();
    @(posedge Reloj);
    #1;
  endtask

  task automatic do_reset();
    bus.subir = 1'b0;
    bus.bajar = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] e, o;
    bus.subir = 1'b0;
    bus.bajar = 1'b0;
    reset = 1'b0;
    #3;
    sb.push_back(mk(0, 0, 0));
    tick();
    e = sb.pop_front();
    o = obs();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset_held actual=%h required=%h", o, e);
    end
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      sb.push_back(mk(0, 0, 0));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_release edge %0d actual=%h required=%h", k, o, e);
      end
    end
  endtask

  task automatic test_full_open();
    logic [12:0] e, o;
    int p;
    do_reset();
    bus.subir = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      p = (k - 1) / PR;
      if (p > TRAV) p = TRAV;
      sb.push_back(mk(p, (k < 1 + TRAV * PR), 0));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL full_open edge %0d actual=%h required=%h", k, o, e);
      end
    end
    bus.subir = 1'b0;
  endtask

  task automatic test_partial_discard();
    logic [12:0] e, o;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 4; k++) begin
        bus.subir = (k <= 3);
        sb.push_back(mk(0, (k <= 3), 0));
        tick();
        e = sb.pop_front();
        o = obs();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL partial rep %0d edge %0d actual=%h required=%h",
                   r, k, o, e);
        end
      end
    end
  endtask

  task automatic test_reversal();
    logic [12:0] e, o;
    do_reset();
    bus.subir = 1'b1;
    for (int k = 1; k <= 1 + 6 * PR; k++) tick();
    o = obs();
    e = mk(6, 1, 0);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reversal_pre actual=%h required=%h", o, e);
    end
    bus.subir = 1'b0;
    bus.bajar = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      sb.push_back(mk((j == 5) ? 5 : 6, (j != 0), 0));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reversal switch+%0d actual=%h required=%h", j, o, e);
      end
    end
    bus.bajar = 1'b0;
  endtask

  task automatic test_lower_limit();
    logic [12:0] e, o;
    do_reset();
    bus.bajar = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      sb.push_back(mk(0, 0, 0));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL lower_limit edge %0d actual=%h required=%h", k, o, e);
      end
    end
    bus.bajar = 1'b0;
  endtask

  task automatic test_fault_reset();
    logic [12:0] e, o;
    do_reset();
    bus.subir = 1'b1;
    for (int k = 1; k <= 2 * PR; k++) begin
      sb.push_back(mk((k - 1) / PR, 1, 0));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL fault_pre edge %0d actual=%h required=%h", k, o, e);
      end
    end
    // Prescaler is at its last count here: the pending step must be dropped.
    bus.bajar = 1'b1;
    sb.push_back(mk(1, 0, 1));
    tick();
    e = sb.pop_front();
    o = obs();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL fault_entry actual=%h required=%h", o, e);
    end
    for (int k = 1; k <= 6; k++) begin
      bus.subir = (k > 3);
      bus.bajar = (k > 5);
      sb.push_back(mk(1, 0, 1));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL fault_sticky %0d actual=%h required=%h", k, o, e);
      end
    end
    bus.subir = 1'b0;
    bus.bajar = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    e = mk(0, 0, 0);
    o = obs();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL fault_async_reset actual=%h required=%h", o, e);
    end
    #2;
    reset = 1'b1;
    bus.subir = 1'b1;
    for (int k = 1; k <= PR + 1; k++) begin
      sb.push_back(mk((k - 1) / PR, 1, 0));
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL post_reset_resume edge %0d actual=%h required=%h",
                 k, o, e);
      end
    end
    bus.subir = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.subir = 1'b0;
    bus.bajar = 1'b0;
    test_reset();
    test_full_open();
    test_partial_discard();
    test_reversal();
    test_lower_limit();
    test_fault_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
